// File: rtl/phi_position_sweep_scheduler.sv
// Sweeps one shared quarter-integer position classifier lane across all
// oscillators. It captures class/stability per oscillator, tracks catastrophe
// dwell, and hands escape requests (floor(n)+0.5 targets) to the n-update logic.
module phi_position_sweep_scheduler #(
  parameter int WIDTH           = 18,
  parameter int FRAC            = 14,
  parameter int NUM_OSCILLATORS = 21,
  parameter int LANE_LAT        = 2,
  parameter int DWELL_W         = 4,
  parameter int DWELL_THRESH    = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_clk_en,
  input  logic                             i_start,
  input  logic [NUM_OSCILLATORS*WIDTH-1:0] i_n_packed,
  output logic [WIDTH-1:0]                 o_lane_n,
  input  logic [1:0]                       i_lane_class,
  input  logic [WIDTH-1:0]                 i_lane_stability,
  output logic [NUM_OSCILLATORS*2-1:0]     o_class_table,
  output logic [NUM_OSCILLATORS*WIDTH-1:0] o_stability_table,
  output logic [4:0]                       o_catastrophe_count,
  output logic                             o_esc_valid,
  input  logic                             i_esc_ready,
  output logic [4:0]                       o_esc_idx,
  output logic [WIDTH-1:0]                 o_esc_target,
  output logic                             o_busy,
  output logic                             o_sweep_done
);
  // 5-bit index/count ports cover up to 31 oscillators
  localparam int IDX_W = 5;
  localparam logic [WIDTH-1:0] FMASK = ~WIDTH'((1 << FRAC) - 1);
  localparam logic [WIDTH-1:0] HALF  = WIDTH'(1 << (FRAC - 1));

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_REPORT} state_t;

  state_t r_state, w_state_nxt;
  logic [IDX_W-1:0]                          r_idx;
  logic [WIDTH-1:0]                          r_lane_n;
  logic [LANE_LAT-1:0]                       r_vld_pipe;
  logic [LANE_LAT-1:0][IDX_W-1:0]            r_idx_pipe;
  logic [LANE_LAT-1:0][WIDTH-1:0]            r_n_pipe;
  logic [NUM_OSCILLATORS-1:0][1:0]           r_class;
  logic [NUM_OSCILLATORS-1:0][WIDTH-1:0]     r_stab;
  logic [NUM_OSCILLATORS-1:0][DWELL_W-1:0]   r_dwell;
  logic [NUM_OSCILLATORS-1:0][WIDTH-1:0]     r_target;
  logic [NUM_OSCILLATORS-1:0]                r_pending;
  logic [IDX_W-1:0]                          r_tally;
  logic [IDX_W-1:0]                          r_count;
  logic                                      r_done;

  logic [NUM_OSCILLATORS-1:0][WIDTH-1:0]     w_n_arr;
  logic                                      w_last, w_cap, w_cap3, w_pend_any, w_xfer;
  logic                                      w_drain_busy;
  logic [IDX_W-1:0]                          w_cap_idx, w_sel, w_tally_nxt;
  logic [WIDTH-1:0]                          w_cap_n;
  logic [DWELL_W-1:0]                        w_dwell_cur, w_dwell_inc;

  assign w_n_arr     = i_n_packed;
  assign w_last      = (r_idx == IDX_W'(NUM_OSCILLATORS - 1));
  assign w_cap       = i_clk_en && r_vld_pipe[LANE_LAT-1];
  assign w_cap_idx   = r_idx_pipe[LANE_LAT-1];
  assign w_cap_n     = r_n_pipe[LANE_LAT-1];
  assign w_cap3      = w_cap && (i_lane_class == 2'd3);
  assign w_dwell_cur = r_dwell[w_cap_idx];
  assign w_dwell_inc = (w_dwell_cur == '1) ? w_dwell_cur : w_dwell_cur + 1'b1;
  assign w_pend_any  = |r_pending;
  assign w_xfer      = i_clk_en && (r_state == S_REPORT) && w_pend_any && i_esc_ready;
  assign w_tally_nxt = r_tally + IDX_W'(w_cap3);

  // Entries still in flight after this edge; the tail is captured on it
  always_comb begin
    w_drain_busy = 1'b0;
    for (int i = 0; i < LANE_LAT - 1; i++) w_drain_busy = w_drain_busy | r_vld_pipe[i];
  end

  // Lowest pending oscillator wins the escape channel
  always_comb begin
    w_sel = '0;
    for (int i = NUM_OSCILLATORS - 1; i >= 0; i--)
      if (r_pending[i]) w_sel = IDX_W'(i);
  end

  // State register, frozen while clk_en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_state <= S_IDLE;
    else if (i_clk_en) r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start)       w_state_nxt = S_ISSUE;
      S_ISSUE:  if (w_last)        w_state_nxt = S_DRAIN;
      S_DRAIN:  if (!w_drain_busy) w_state_nxt = S_REPORT;
      S_REPORT: if (!w_pend_any)   w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state and pending set
  always_comb begin
    o_busy       = (r_state != S_IDLE);
    o_esc_valid  = (r_state == S_REPORT) && w_pend_any;
    o_esc_idx    = o_esc_valid ? w_sel : '0;
    o_esc_target = o_esc_valid ? r_target[w_sel] : '0;
  end

  assign o_lane_n            = r_lane_n;
  assign o_class_table       = r_class;
  assign o_stability_table   = r_stab;
  assign o_catastrophe_count = r_count;
  assign o_sweep_done        = r_done;

  // Issue index and registered lane drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_lane_n <= '0;
    end else if (i_clk_en) begin
      if (r_state == S_ISSUE) begin
        r_idx    <= w_last ? '0 : r_idx + 1'b1;
        r_lane_n <= w_n_arr[r_idx];
      end else begin
        r_idx <= '0;
      end
    end
  end

  // Tag pipeline: carries index and issued n alongside the classifier latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_idx_pipe <= '0;
      r_n_pipe   <= '0;
    end else if (i_clk_en) begin
      r_vld_pipe[0] <= (r_state == S_ISSUE);
      r_idx_pipe[0] <= r_idx;
      r_n_pipe[0]   <= w_n_arr[r_idx];
      for (int i = 1; i < LANE_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_idx_pipe[i] <= r_idx_pipe[i-1];
        r_n_pipe[i]   <= r_n_pipe[i-1];
      end
    end
  end

  // Result capture, dwell tracking and escape bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_class   <= '0;
      r_stab    <= '0;
      r_dwell   <= '0;
      r_target  <= '0;
      r_pending <= '0;
    end else begin
      if (w_cap) begin
        r_class[w_cap_idx] <= i_lane_class;
        r_stab[w_cap_idx]  <= i_lane_stability;
        if (i_lane_class == 2'd3) begin
          r_dwell[w_cap_idx] <= w_dwell_inc;
          if (w_dwell_inc >= DWELL_W'(DWELL_THRESH)) begin
            r_pending[w_cap_idx] <= 1'b1;
            r_target[w_cap_idx]  <= (w_cap_n & FMASK) | HALF;
          end
        end else begin
          r_dwell[w_cap_idx] <= '0;
        end
      end
      if (w_xfer) begin
        r_pending[w_sel] <= 1'b0;
        r_dwell[w_sel]   <= '0;
      end
    end
  end

  // Per-sweep catastrophe tally, published when the drain completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tally <= '0;
      r_count <= '0;
    end else if (i_clk_en) begin
      if (r_state == S_IDLE && i_start) r_tally <= '0;
      else                              r_tally <= w_tally_nxt;
      if (r_state == S_DRAIN && !w_drain_busy) r_count <= w_tally_nxt;
    end
  end

  // One-cycle completion pulse as the FSM returns to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= i_clk_en && (r_state == S_REPORT) && !w_pend_any;
  end

endmodule
